// File: rtl/inject_sched.sv
// Round-robin injection scheduler and drain/config sequencer in front of one node_4.
// Define INJ_STATS_EN to build the issue_cnt counter; otherwise issue_cnt is tied to 0.
module inject_sched #(
  parameter int LG_NUMPROCS   = 2,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int NUM_REQ       = 4,
  parameter int INJ_GAP       = 2,
  parameter int DRAIN_CYCLES  = 8,
  parameter int CFG_HOLD      = 2,
  localparam int FLIT_CHILD_WIDTH = PAYLOAD_WIDTH + 52,
  localparam int VALID_POS        = PAYLOAD_WIDTH + 49,
  localparam int NEWCOMM_WIDTH    = (LG_NUMPROCS + 2) * 9 + LG_NUMPROCS * 2 + 2 + 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*FLIT_CHILD_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ*3-1:0]                req_dir,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                cfg_valid,
  input  logic [NEWCOMM_WIDTH-1:0]            cfg_data,
  output logic                                cfg_ready,
  output logic [FLIT_CHILD_WIDTH-1:0]         inject_xpos,
  output logic [FLIT_CHILD_WIDTH-1:0]         inject_ypos,
  output logic [FLIT_CHILD_WIDTH-1:0]         inject_xneg,
  output logic [FLIT_CHILD_WIDTH-1:0]         inject_yneg,
  output logic [FLIT_CHILD_WIDTH-1:0]         reduce_me,
  output logic [NEWCOMM_WIDTH-1:0]            newcomm,
  output logic                                busy,
  output logic [7:0]                          drop_cnt,
  output logic [31:0]                         issue_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int HW = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;
  localparam logic [FLIT_CHILD_WIDTH-1:0] VALID_BIT = FLIT_CHILD_WIDTH'(1) << VALID_POS;

  typedef enum logic [1:0] {RUN, DRAIN, CFG} state_t;

  state_t                      state, state_next;
  logic [DW-1:0]               drain_cnt;
  logic [HW-1:0]               hold_cnt;
  logic [PW-1:0]               ptr, grant_idx, idx;
  logic                        found, issue_valid;
  logic [NUM_REQ-1:0]          elig;
  logic [7:0]                  port_free;
  logic [2:0]                  grant_dir;
  logic [FLIT_CHILD_WIDTH-1:0] issue_flit;
  logic [2:0]                  dir  [NUM_REQ];
  logic [FLIT_CHILD_WIDTH-1:0] flit [NUM_REQ];
  logic [CW-1:0]               cool [5];
  logic [FLIT_CHILD_WIDTH-1:0] port_q [5];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dir[g]  = req_dir[g*3 +: 3];
    assign flit[g] = req_flit[g*FLIT_CHILD_WIDTH +: FLIT_CHILD_WIDTH];
  end

  // Illegal directions (5-7) have no cooldown, so they always look free.
  always_comb begin
    port_free = '1;
    for (int p = 0; p < 5; p++) port_free[p] = (cool[p] == '0);
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && port_free[dir[i]] && (state == RUN) && !cfg_valid;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    req_ready = '0;
    if (found) req_ready[grant_idx] = 1'b1;
    grant_dir   = dir[grant_idx];
    issue_flit  = flit[grant_idx] | VALID_BIT;
    issue_valid = found && (grant_dir <= 3'd4);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      drop_cnt <= '0;
      for (int p = 0; p < 5; p++) begin
        port_q[p] <= '0;
        cool[p]   <= '0;
      end
    end else begin
      if (found) ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (found && !issue_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      for (int p = 0; p < 5; p++) begin
        if (issue_valid && grant_dir == 3'(p)) begin
          port_q[p] <= issue_flit;
          cool[p]   <= CW'(INJ_GAP - 1);
        end else begin
          port_q[p] <= '0;
          if (cool[p] != '0) cool[p] <= cool[p] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Drain ends when the counter would reach zero, giving exactly DRAIN_CYCLES idle cycles.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    case (state)
      RUN:     if (cfg_valid) state_next = DRAIN;
      DRAIN:   if (drain_cnt <= DW'(1)) state_next = CFG;
      CFG: begin
        if (hold_cnt == '0) begin
          cfg_ready  = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_cnt <= '0;
      hold_cnt  <= '0;
      newcomm   <= '0;
    end else begin
      if (state == RUN && state_next == DRAIN) drain_cnt <= DW'(DRAIN_CYCLES);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (state != CFG && state_next == CFG) hold_cnt <= HW'(CFG_HOLD - 1);
      else if (state == CFG && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      newcomm <= (state_next == CFG) ? cfg_data : '0;
    end
  end

  assign busy        = (state != RUN);
  assign inject_xpos = port_q[0];
  assign inject_ypos = port_q[1];
  assign inject_xneg = port_q[2];
  assign inject_yneg = port_q[3];
  assign reduce_me   = port_q[4];

`ifdef INJ_STATS_EN
  logic [31:0] issue_q;

  always_ff @(posedge clk) begin
    if (!rst)             issue_q <= '0;
    else if (issue_valid) issue_q <= issue_q + 32'd1;
  end

  assign issue_cnt = issue_q;
`else
  assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_inject_sched.sv
// Directed self-checking bench for inject_sched at default parameters.
// Expected issue_cnt follows whether INJ_STATS_EN is defined for the build.
module tb_inject_sched;

  localparam int FW = 84;
  localparam int VP = 81;
  localparam int NW = 50;
  localparam int NR = 4;
  localparam logic [FW-1:0] VBIT = {{(FW-1){1'b0}}, 1'b1} << VP;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*FW-1:0] req_flit;
  logic [NR*3-1:0]  req_dir;
  logic [NR-1:0]    req_ready;
  logic             cfg_valid;
  logic [NW-1:0]    cfg_data;
  logic             cfg_ready;
  logic [FW-1:0]    inject_xpos, inject_ypos, inject_xneg, inject_yneg, reduce_me;
  logic [NW-1:0]    newcomm;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic [31:0]      issue_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  inject_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_flit(req_flit), .req_dir(req_dir), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .inject_xpos(inject_xpos), .inject_ypos(inject_ypos), .inject_xneg(inject_xneg),
    .inject_yneg(inject_yneg), .reduce_me(reduce_me),
    .newcomm(newcomm), .busy(busy), .drop_cnt(drop_cnt), .issue_cnt(issue_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [2:0] d, input logic [FW-1:0] f);
    req_valid[i]       = v;
    req_dir[i*3 +: 3]  = d;
    req_flit[i*FW +: FW] = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst       = 1'b0;
    req_valid = '0;
    req_flit  = '0;
    req_dir   = '0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  function automatic logic [FW-1:0] portVal(input int p);
    case (p)
      0:       return inject_xpos;
      1:       return inject_ypos;
      2:       return inject_xneg;
      3:       return inject_yneg;
      default: return reduce_me;
    endcase
  endfunction

  function automatic logic [31:0] expIssues(input int n);
`ifdef INJ_STATS_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  logic [FW-1:0] flits2 [NR];
  logic [FW-1:0] fa, fb, ports_or;
  logic [NW-1:0] cd;
  int            accepted;

  initial begin
    fa = 84'h0000000000000_0C0FFEE;
    fb = 84'h800000000000000000055;
    cd = 50'h3_1234_5678_9ABC;
    flits2[0] = 84'h111;
    flits2[1] = 84'h2220000;
    flits2[2] = 84'h3330000000000;
    flits2[3] = 84'h444 | VBIT;

    // reset state
    rst       = 1'b0;
    req_valid = '0;
    req_flit  = '0;
    req_dir   = '0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    tick();
    tick();
    for (int p = 0; p < 5; p++) checkOutput($sformatf("rst_port%0d", p), portVal(p), '0);
    checkOutput("rst_newcomm", newcomm, '0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_issue_cnt", issue_cnt, 0);
    rst = 1'b1;
    #1;

    // single flit on xpos, one cycle wide
    applyStimulus(0, 1'b1, 3'd0, 84'h1234);
    #1;
    checkOutput("t1_ready", req_ready, 4'b0001);
    tick();
    applyStimulus(0, 1'b0, 3'd0, '0);
    checkOutput("t1_xpos", inject_xpos, 84'h1234 | VBIT);
    for (int p = 1; p < 5; p++) checkOutput($sformatf("t1_idle%0d", p), portVal(p), '0);
    tick();
    checkOutput("t1_xpos_clear", inject_xpos, '0);

    // four requesters to distinct ports, round-robin order
    resetDut();
    for (int k = 0; k < NR; k++) applyStimulus(k, 1'b1, 3'(k), flits2[k]);
    #1;
    for (int k = 0; k < NR; k++) begin
      checkOutput($sformatf("t2_ready%0d", k), req_ready, 4'b0001 << k);
      tick();
      applyStimulus(k, 1'b0, 3'(k), '0);
      #1;
      for (int p = 0; p < 5; p++)
        checkOutput($sformatf("t2_c%0d_port%0d", k, p), portVal(p), (p == k) ? (flits2[k] | VBIT) : '0);
    end
    tick();
    for (int p = 0; p < 5; p++) checkOutput($sformatf("t2_end_port%0d", p), portVal(p), '0);

    // two requesters on ypos, spacing of two cycles
    resetDut();
    applyStimulus(0, 1'b1, 3'd1, fa);
    applyStimulus(1, 1'b1, 3'd1, fb);
    #1;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("t3_ready_c%0d", c), req_ready,
                  (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000);
      tick();
      checkOutput($sformatf("t3_ypos_c%0d", c), inject_ypos,
                  (c % 2 == 0) ? ((((c / 2) % 2 == 0) ? fa : fb) | VBIT) : '0);
    end
    req_valid = '0;
    checkOutput("t3_issue_cnt", issue_cnt, expIssues(4));

    // illegal direction, drop counter saturation
    resetDut();
    applyStimulus(2, 1'b1, 3'd6, fa);
    #1;
    accepted = 0;
    ports_or = '0;
    for (int i = 0; i < 300; i++) begin
      if (req_ready == 4'b0100) accepted++;
      tick();
      for (int p = 0; p < 5; p++) ports_or = ports_or | portVal(p);
      if (i == 9)   checkOutput("t4_drop_10", drop_cnt, 10);
      if (i == 254) checkOutput("t4_drop_255", drop_cnt, 255);
    end
    req_valid = '0;
    checkOutput("t4_accepted", accepted, 300);
    checkOutput("t4_ports_idle", ports_or, '0);
    checkOutput("t4_drop_sat", drop_cnt, 255);
    checkOutput("t4_issue_cnt", issue_cnt, expIssues(0));

    // config write with pending requests
    resetDut();
    applyStimulus(0, 1'b1, 3'd0, fa);
    applyStimulus(1, 1'b1, 3'd1, fb);
    cfg_data  = cd;
    cfg_valid = 1'b1;
    #1;
    for (int c = 0; c <= 10; c++) begin
      checkOutput($sformatf("t5_ready_c%0d", c), req_ready, 4'b0000);
      checkOutput($sformatf("t5_busy_c%0d", c), busy, (c >= 1) ? 1 : 0);
      checkOutput($sformatf("t5_newcomm_c%0d", c), newcomm, (c >= 9) ? cd : '0);
      checkOutput($sformatf("t5_cfg_ready_c%0d", c), cfg_ready, (c == 10) ? 1 : 0);
      tick();
    end
    cfg_valid = 1'b0;
    #1;
    checkOutput("t5_resume_ready", req_ready, 4'b0001);
    checkOutput("t5_resume_busy", busy, 0);
    checkOutput("t5_resume_newcomm", newcomm, '0);
    checkOutput("t5_resume_cfg_ready", cfg_ready, 0);
    req_valid = '0;

    // reset in the middle of a config write
    resetDut();
    applyStimulus(0, 1'b1, 3'd0, fa);
    #1;
    tick();
    applyStimulus(0, 1'b0, 3'd0, '0);
    checkOutput("t6_issue_before", issue_cnt, expIssues(1));
    cfg_data  = cd;
    cfg_valid = 1'b1;
    repeat (9) tick();
    checkOutput("t6_in_cfg_busy", busy, 1);
    checkOutput("t6_in_cfg_newcomm", newcomm, cd);
    rst = 1'b0;
    tick();
    checkOutput("t6_rst_newcomm", newcomm, '0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_cfg_ready", cfg_ready, 0);
    checkOutput("t6_rst_issue_cnt", issue_cnt, 0);
    cfg_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_after_cfg_ready", cfg_ready, 0);
    checkOutput("t6_after_busy", busy, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
